// File: rtl/imm_encode_loader_if.sv
// imm_encode_loader_if: instruction beat stream, memory write port and session status of the loader.
interface imm_encode_loader_if #(
    parameter int INSTR_WIDTH = 32,
    parameter int ADDR_WIDTH  = 10
);
    logic                   start;
    logic                   in_valid;
    logic                   in_ready;
    logic                   in_last;
    logic [1:0]             in_type;
    logic [6:0]             in_opcode;
    logic [4:0]             in_rd;
    logic [2:0]             in_funct3;
    logic [4:0]             in_rs1;
    logic [4:0]             in_rs2;
    logic [6:0]             in_funct7;
    logic [INSTR_WIDTH-1:0] in_imm;
    logic                   mem_we;
    logic [ADDR_WIDTH-1:0]  mem_addr;
    logic [INSTR_WIDTH-1:0] mem_wdata;
    logic                   busy;
    logic                   done;
    logic [1:0]             err;
    logic [ADDR_WIDTH:0]    count;

    modport slave (
        input  start, in_valid, in_last, in_type, in_opcode, in_rd, in_funct3,
               in_rs1, in_rs2, in_funct7, in_imm,
        output in_ready, mem_we, mem_addr, mem_wdata, busy, done, err, count
    );
    modport master (
        output start, in_valid, in_last, in_type, in_opcode, in_rd, in_funct3,
               in_rs1, in_rs2, in_funct7, in_imm,
        input  in_ready, mem_we, mem_addr, mem_wdata, busy, done, err, count
    );
endinterface

// File: rtl/imm_encode_loader.sv
// imm_encode_loader: packs decoded fields into RV32I words and writes them sequentially to instruction memory.
// Define IMM_RANGE_CHECK_EN to reject out-of-range immediates (err[0]); otherwise they are truncated.
module imm_encode_loader #(
    parameter int INSTR_WIDTH = 32,
    parameter int ADDR_WIDTH  = 10
) (
    input logic clk,
    input logic rst_n,
    imm_encode_loader_if.slave bus
);
    typedef enum logic [1:0] {IDLE, LOAD, DRAIN, DONE} state_t;
    localparam logic [ADDR_WIDTH:0] ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

    state_t                 state_q, state_d;
    logic                   armed_q, we_q;
    logic [ADDR_WIDTH-1:0]  addr_q;
    logic [INSTR_WIDTH-1:0] wdata_q, enc, imm;
    logic [ADDR_WIDTH:0]    iss_q, cnt_q;
    logic [1:0]             err_q;
    logic                   go, acc, bad, ovf, wr;

    assign imm = bus.in_imm;
    assign go  = (state_q == IDLE || state_q == DONE) && bus.start && armed_q;
    assign acc = state_q == LOAD && bus.in_valid;
    // iss_q counts issued writes including the one still in flight, so it reaches DEPTH one beat before count does
    assign ovf = iss_q[ADDR_WIDTH];
    assign wr  = acc && !bad && !ovf;

`ifdef IMM_RANGE_CHECK_EN
    logic s_ok, b_ok;
    assign s_ok = (&imm[INSTR_WIDTH-1:11]) | ~(|imm[INSTR_WIDTH-1:11]);
    assign b_ok = ((&imm[INSTR_WIDTH-1:12]) | ~(|imm[INSTR_WIDTH-1:12])) & ~imm[0];
    assign bad  = bus.in_type == 2'b11 ? 1'b0 : bus.in_type == 2'b10 ? !b_ok : !s_ok;
`else
    logic unused_imm;
    assign unused_imm = ^imm[INSTR_WIDTH-1:13];
    assign bad        = 1'b0;
`endif

    always_comb begin
        enc = bus.in_type == 2'b11 ? {bus.in_funct7, bus.in_rs2, bus.in_rs1, bus.in_funct3, bus.in_rd, bus.in_opcode}
            : bus.in_type == 2'b00 ? {imm[11:0], bus.in_rs1, bus.in_funct3, bus.in_rd, bus.in_opcode}
            : bus.in_type == 2'b01 ? {imm[11:5], bus.in_rs2, bus.in_rs1, bus.in_funct3, imm[4:0], bus.in_opcode}
            : {imm[12], imm[10:5], bus.in_rs2, bus.in_rs1, bus.in_funct3, imm[4:1], imm[11], bus.in_opcode};
    end

    always_comb begin
        state_d      = go ? LOAD
                     : (acc && bus.in_last) ? DRAIN
                     : state_q == DRAIN ? DONE
                     : state_q;
        bus.in_ready = state_q == LOAD;
        bus.busy     = state_q == LOAD || state_q == DRAIN;
        bus.done     = state_q == DONE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            armed_q <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            iss_q   <= '0;
            cnt_q   <= '0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            armed_q <= 1'b1;
            we_q    <= wr;
            if (wr) begin
                addr_q  <= iss_q[ADDR_WIDTH-1:0];
                wdata_q <= enc;
            end
            if (go) begin
                iss_q <= '0;
                cnt_q <= '0;
                err_q <= '0;
            end else begin
                if (wr) iss_q <= iss_q + ONE;
                if (we_q) cnt_q <= cnt_q + ONE;
                if (acc) err_q <= err_q | {ovf, bad};
            end
        end
    end

    assign bus.mem_we    = we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.err       = err_q;
    assign bus.count     = cnt_q;
endmodule

// File: tb/tb_imm_encode_loader.sv
// tb_imm_encode_loader: directed scoreboard bench for a default-size loader and a 4-word loader sharing one stream.
module tb_imm_encode_loader;
    typedef struct packed {
        logic [9:0]  a;
        logic [31:0] d;
        logic [1:0]  t;
        logic [31:0] imm;
        logic        rt;
    } ent_t;

    logic clk = 1'b0, rst_n = 1'b0;
    logic start_a = 1'b0, start_b = 1'b0, valid = 1'b0, last = 1'b0;
    logic [1:0] typ = '0;
    logic [6:0] op = '0, f7 = '0;
    logic [4:0] rd = '0, rs1 = '0, rs2 = '0;
    logic [2:0] f3 = '0;
    logic [31:0] imm = '0;
    int checks = 0, errors = 0, na = 0, nb = 0;
    ent_t exp_a[$], obs_a[$], exp_b[$], obs_b[$];
    ent_t ma, mb;

    always #5 clk = ~clk;

    imm_encode_loader_if #(.INSTR_WIDTH(32), .ADDR_WIDTH(10)) ia ();
    imm_encode_loader_if #(.INSTR_WIDTH(32), .ADDR_WIDTH(2))  ib ();

    assign ia.start = start_a;
    assign ib.start = start_b;
    assign {ia.in_valid, ia.in_last, ia.in_type, ia.in_opcode, ia.in_rd, ia.in_funct3, ia.in_rs1, ia.in_rs2, ia.in_funct7, ia.in_imm}
         = {valid, last, typ, op, rd, f3, rs1, rs2, f7, imm};
    assign {ib.in_valid, ib.in_last, ib.in_type, ib.in_opcode, ib.in_rd, ib.in_funct3, ib.in_rs1, ib.in_rs2, ib.in_funct7, ib.in_imm}
         = {valid, last, typ, op, rd, f3, rs1, rs2, f7, imm};

    imm_encode_loader #(.INSTR_WIDTH(32), .ADDR_WIDTH(10)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ia.slave));
    imm_encode_loader #(.INSTR_WIDTH(32), .ADDR_WIDTH(2))  dut_b (.clk(clk), .rst_n(rst_n), .bus(ib.slave));

    always @(negedge clk) begin
        if (ia.mem_we === 1'b1) begin
            ma = '0;
            ma.a = ia.mem_addr;
            ma.d = ia.mem_wdata;
            obs_a.push_back(ma);
        end
    end

    always @(negedge clk) begin
        if (ib.mem_we === 1'b1) begin
            mb = '0;
            mb.a = {8'b0, ib.mem_addr};
            mb.d = ib.mem_wdata;
            obs_b.push_back(mb);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // Immediate extender: recovers the immediate from an encoded word
    function automatic logic [31:0] ext(input logic [31:0] w, input logic [1:0] t);
        ext = t == 2'b00 ? {{20{w[31]}}, w[31:20]}
            : t == 2'b01 ? {{20{w[31]}}, w[31:25], w[11:7]}
            : {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic go(input bit sel);
        if (sel) begin start_b = 1'b1; nb = 0; end
        else begin start_a = 1'b1; na = 0; end
        @(posedge clk); #1;
        start_a = 1'b0;
        start_b = 1'b0;
        chk("busy_after_start", sel ? ib.busy : ia.busy, 1);
    endtask

    task automatic beat(input bit sel, input logic [1:0] t, input logic [6:0] o, input logic [4:0] d,
                        input logic [2:0] fn3, input logic [4:0] r1, input logic [4:0] r2, input logic [6:0] fn7,
                        input logic [31:0] im, input bit l, input bit wr, input logic [31:0] data, input bit rt);
        int n = 0;
        ent_t e;
        {typ, op, rd, f3, rs1, rs2, f7, imm, last, valid} = {t, o, d, fn3, r1, r2, fn7, im, l, 1'b1};
        while (!(sel ? ib.in_ready : ia.in_ready) && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk("in_ready", sel ? ib.in_ready : ia.in_ready, 1);
        @(posedge clk); #1;
        valid = 1'b0;
        last = 1'b0;
        if (wr) begin
            e = '0;
            e.a = sel ? nb[9:0] : na[9:0];
            e.d = data;
            e.t = t;
            e.imm = im;
            e.rt = rt;
            if (sel) begin exp_b.push_back(e); nb++; end
            else begin exp_a.push_back(e); na++; end
        end
    endtask

    task automatic wait_done(input bit sel, input string tag);
        int n = 0;
        while ((sel ? ib.done : ia.done) !== 1'b1 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk(tag, sel ? ib.done : ia.done, 1);
        chk({tag, "_busy"}, sel ? ib.busy : ia.busy, 0);
    endtask

    task automatic drain(input string tag);
        ent_t e, o;
        while (exp_a.size() > 0 && obs_a.size() > 0) begin
            e = exp_a.pop_front();
            o = obs_a.pop_front();
            chk({tag, "_addr"}, o.a, e.a);
            chk({tag, "_data"}, o.d, e.d);
            if (e.rt) chk({tag, "_roundtrip"}, ext(o.d, e.t), e.imm);
        end
        while (exp_b.size() > 0 && obs_b.size() > 0) begin
            e = exp_b.pop_front();
            o = obs_b.pop_front();
            chk({tag, "_addr_b"}, o.a, e.a);
            chk({tag, "_data_b"}, o.d, e.d);
        end
        chk({tag, "_missing_writes"}, exp_a.size() + exp_b.size(), 0);
        chk({tag, "_extra_writes"}, obs_a.size() + obs_b.size(), 0);
    endtask

    task automatic all_zero(input string tag);
        chk({tag, "_we"}, ia.mem_we, 0);
        chk({tag, "_addr"}, ia.mem_addr, 0);
        chk({tag, "_wdata"}, ia.mem_wdata, 0);
        chk({tag, "_busy"}, ia.busy, 0);
        chk({tag, "_done"}, ia.done, 0);
        chk({tag, "_err"}, ia.err, 0);
        chk({tag, "_count"}, ia.count, 0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        all_zero("reset");
        rst_n = 1'b1;
        start_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0;
        chk("start_at_reset_release_ignored", ia.busy, 0);
        @(posedge clk); #1;

        go(0);
        beat(0, 2'b00, 7'h13, 5'd1, 3'd0, 5'd0, 5'd0, 7'd0, 32'd5, 1, 1, 32'h0050_0093, 1);
        wait_done(0, "i_done");
        chk("i_count", ia.count, 1);
        chk("i_err", ia.err, 0);
        drain("i");

        go(0);
        beat(0, 2'b01, 7'h23, 5'd0, 3'd2, 5'd1, 5'd2, 7'd0, 32'd8, 0, 1, 32'h0020_A423, 1);
        beat(0, 2'b10, 7'h63, 5'd0, 3'd0, 5'd1, 5'd2, 7'd0, -32'sd4, 1, 1, 32'hFE20_8EE3, 1);
        wait_done(0, "sb_done");
        chk("sb_count", ia.count, 2);
        drain("sb");

        go(0);
        beat(0, 2'b11, 7'h33, 5'd3, 3'd0, 5'd1, 5'd2, 7'd0, 32'hDEAD_BEEF, 1, 1, 32'h0020_81B3, 0);
        wait_done(0, "r_done");
        chk("r_count", ia.count, 1);
        drain("r");

        go(0);
`ifdef IMM_RANGE_CHECK_EN
        beat(0, 2'b00, 7'h13, 5'd1, 3'd0, 5'd0, 5'd0, 7'd0, 32'd2048, 0, 0, 32'h0, 0);
        beat(0, 2'b10, 7'h63, 5'd0, 3'd0, 5'd1, 5'd2, 7'd0, 32'd3, 1, 0, 32'h0, 0);
        wait_done(0, "range_done");
        chk("range_err", ia.err, 2'b01);
        chk("range_count", ia.count, 0);
`else
        beat(0, 2'b00, 7'h13, 5'd1, 3'd0, 5'd0, 5'd0, 7'd0, 32'd2048, 0, 1, 32'h8000_0093, 0);
        beat(0, 2'b10, 7'h63, 5'd0, 3'd0, 5'd1, 5'd2, 7'd0, 32'd3, 1, 1, 32'h0020_8163, 0);
        wait_done(0, "range_done");
        chk("range_err", ia.err, 2'b00);
        chk("range_count", ia.count, 2);
`endif
        drain("range");

        go(1);
        for (int i = 0; i < 5; i++)
            beat(1, 2'b11, 7'h33, i[4:0], 3'd0, 5'd0, 5'd0, 7'd0, 32'd0, i == 4, i < 4, (i << 7) | 32'h33, 0);
        wait_done(1, "ovf_done");
        chk("ovf_err", ib.err, 2'b10);
        chk("ovf_count", ib.count, 4);
        drain("ovf");

        go(0);
        {typ, op, rd, f3, rs1, rs2, f7, imm, last, valid} = {2'b00, 7'h13, 5'd2, 3'd0, 5'd0, 5'd0, 7'd0, 32'd1, 1'b0, 1'b1};
        @(posedge clk); #1;
        valid = 1'b0;
        rst_n = 1'b0;
        #1;
        all_zero("midreset");
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        go(0);
        beat(0, 2'b00, 7'h13, 5'd1, 3'd0, 5'd0, 5'd0, 7'd0, 32'd5, 1, 1, 32'h0050_0093, 1);
        wait_done(0, "restart_done");
        chk("restart_count", ia.count, 1);
        drain("restart");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/imm_encode_loader.md
# imm_encode_loader

Streaming instruction encoder and program loader: accepts decoded instruction fields plus a sign-extended immediate over a valid/ready stream, packs them into RV32I 32-bit words (the inverse of the immediate extender's I/S/B field placement), and writes them sequentially into instruction memory. It sits between the testbench or boot interface and the instruction memory write port. It reports progress, completion and sticky errors to the host.

## Interface
- `INSTR_WIDTH`, 32, instruction and immediate width
- `ADDR_WIDTH`, 10, word-address width; capacity `DEPTH = 2**ADDR_WIDTH` words
- `clk` input 1: single clock, rising edge
- `rst_n` input 1: asynchronous, active-low reset
- `start` input 1: begin a load session; pulse
- `in_valid` input 1: beat valid
- `in_ready` output 1: beat accepted when `in_valid && in_ready`
- `in_last` input 1: final beat of the session
- `in_type` input 2: `00` I, `01` S, `10` B, `11` R (no immediate); same encoding as `immSrc`
- `in_opcode` input 7; `in_rd` input 5; `in_funct3` input 3; `in_rs1` input 5; `in_rs2` input 5; `in_funct7` input 7: instruction fields
- `in_imm` input INSTR_WIDTH: sign-extended byte-offset immediate
- `mem_we` output 1: write strobe
- `mem_addr` output ADDR_WIDTH: word index
- `mem_wdata` output INSTR_WIDTH: encoded word
- `busy` output 1: session in progress
- `done` output 1: session complete; held until the next `start` or reset
- `err` output 2: sticky; `[0]` immediate out of range, `[1]` overflow
- `count` output ADDR_WIDTH+1: words written this session

## Operation
- FSM states: IDLE, LOAD, DRAIN, DONE. All outputs reset to 0; the FSM resets to IDLE.
- IDLE or DONE: `start` goes to LOAD and clears `count`, `err`, `done` and the address counter.
- LOAD: `in_ready = 1`. An accepted beat with `in_last` goes to DRAIN. `start` is ignored in LOAD and DRAIN.
- DRAIN: one cycle for the final pending write. Then DONE: `done = 1`, `busy = 0`.
- `busy = 1` in LOAD and DRAIN.
- Encoding by `in_type`:
  - R: `{funct7, rs2, rs1, funct3, rd, opcode}`.
  - I: `{imm[11:0], rs1, funct3, rd, opcode}`.
  - S: `{imm[11:5], rs2, rs1, funct3, imm[4:0], opcode}`.
  - B: `{imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode}`.
  - Fields that a type does not use are ignored.
- Range check, which requires the macro:
  - I/S: `in_imm` must lie in -2048..2047.
  - B: `in_imm` must lie in -4096..4094 and `imm[0]` must be 0.
  - On violation: the beat is consumed, nothing is written, the address does not advance, and `err[0]` is set.
- Overflow: a beat accepted when `count == DEPTH` is consumed and dropped, and `err[1]` is set. `in_ready` stays high so that the session can still reach `in_last`.
- A dropped `in_last` beat still ends the session.
- The address counter is ADDR_WIDTH bits wide and never wraps within a session, because writes are blocked at DEPTH.
- Reset mid-session: all state and outputs return to reset values immediately and a pending write is discarded.

## Timing
- One pipeline stage: a beat accepted at edge N produces `mem_we = 1` with `mem_addr`/`mem_wdata` during cycle N+1, and only for that cycle.
- `count` increments on the same edge that retires the write.
- Back-to-back beats give one write per cycle. `mem_addr` increments by 1 from 0.
- `done` rises the cycle after the last write strobe, or the cycle after the final beat if that beat was dropped.
- `start` asserted together with reset deassertion is ignored. The first `start` is sampled one edge later.
- `err` bits update on the edge after the offending beat and are held until `start` or reset.

## Configuration
- `IMM_RANGE_CHECK_EN` defined: range checks are active and `err[0]` is live.
- Not defined: there is no checking logic. The immediate is silently truncated to the field bits, every beat is written, and `err[0]` is tied to 0. Overflow detection is always present.

## Test plan
- I-type: `start`, then type 00, opcode 0x13, rd 1, rs1 0, funct3 0, imm 5, `in_last` -> `mem_we` the next cycle with addr 0, data 0x00500093. `done` follows; `count` = 1.
- S then B back-to-back:
  - Beat 1: sw, opcode 0x23, rs1 1, rs2 2, funct3 2, imm 8.
  - Beat 2: beq, opcode 0x63, rs1 1, rs2 2, imm -4.
  - Expected: 0x0020A423 at addr 0 and 0xFE208EE3 at addr 1 on consecutive cycles.
- R-type add x3,x1,x2 (funct7 0, opcode 0x33) -> 0x002081B3. Round-trip: feed the I/S/B words into the extender with the matching `immSrc` -> `immExt` equals `in_imm`.
- Range, with macro defined: I imm 2048, then B imm 3 -> no writes, `err` = 01, `count` = 0. Without the macro: both beats are written, and the I beat gives imm field 0x800.
- Overflow: ADDR_WIDTH = 2, send 5 beats -> 4 writes at addr 0..3, 5th dropped, `err` = 10, `count` = 4, `done` = 1.
- Reset: assert `rst_n` low mid-stream with a write pending -> no strobe and all outputs 0. Then a new `start` loads from addr 0.
